// File: rtl/ula_acc_seq.sv
// Sequential accumulator/controller around an external combinational 4-bit ALU.
// Commands arrive over valid/ready; results and flags leave over a second valid/ready.
module ula_acc_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_b,
  output logic [3:0]       alu_a_out,
  output logic [3:0]       alu_b_out,
  output logic [2:0]       alu_op_out,
  input  logic [3:0]       alu_res_in,
  input  logic             alu_c_in,
  input  logic             alu_v_in,
  input  logic             alu_z_in,
  input  logic             alu_n_in,
  output logic [3:0]       acc_out,
  output logic [3:0]       flags_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CMD_EXEC  = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_NOP   = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  state_t            state_q;
  state_t            state_d;
  cmd_t              cmd_q;
  logic [3:0]        acc_q;
  logic [3:0]        flags_q;
  logic [CNT_W-1:0]  count_q;
  logic [3:0]        alu_a_q;
  logic [3:0]        alu_b_q;
  logic [2:0]        alu_op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // in_ready is additionally gated by rst so it reads 0 throughout reset.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_EXEC == state_q ? S_DONE : S_IDLE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= CMD_NOP;
      acc_q    <= '0;
      flags_q  <= 4'b0010;
      count_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cmd_q    <= cmd_t'(in_cmd);
            alu_a_q  <= acc_q;
            alu_b_q  <= in_b;
            alu_op_q <= in_op;
          end
        end
        S_EXEC: begin
          unique case (cmd_q)
            CMD_EXEC: begin
              acc_q   <= alu_res_in;
              flags_q <= {alu_c_in, alu_v_in, alu_z_in, alu_n_in};
            end
            CMD_LOAD: begin
              acc_q   <= alu_b_q;
              flags_q <= {2'b00, (alu_b_q == 4'd0), alu_b_q[3]};
            end
            CMD_CLEAR: begin
              acc_q   <= '0;
              flags_q <= 4'b0010;
            end
            default: ;
          endcase
          count_q <= count_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign alu_a_out    = alu_a_q;
  assign alu_b_out    = alu_b_q;
  assign alu_op_out   = alu_op_q;
  assign acc_out      = acc_q;
  assign flags_out    = flags_q;
  assign op_count_out = count_q;

endmodule

// File: tb/tb_ula_acc_seq.sv
// Directed bench for ula_acc_seq with a reference ALU on the ALU ports and a
// scoreboard of expected acc/flags/count per accepted command.
module tb_ula_acc_seq;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_cmd;
  logic [2:0]       in_op;
  logic [3:0]       in_b;
  logic [3:0]       alu_a_out;
  logic [3:0]       alu_b_out;
  logic [2:0]       alu_op_out;
  logic [3:0]       alu_res_in;
  logic             alu_c_in;
  logic             alu_v_in;
  logic             alu_z_in;
  logic             alu_n_in;
  logic [3:0]       acc_out;
  logic [3:0]       flags_out;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_count_out;

  always #5 clk = ~clk;

  ula_acc_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op(in_op), .in_b(in_b),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_op_out(alu_op_out),
    .alu_res_in(alu_res_in), .alu_c_in(alu_c_in), .alu_v_in(alu_v_in),
    .alu_z_in(alu_z_in), .alu_n_in(alu_n_in),
    .acc_out(acc_out), .flags_out(flags_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_count_out(op_count_out)
  );

  // Returns {C,V,Z,N,res[3:0]}
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    logic [3:0] r;
    logic [4:0] w;
    logic       c;
    logic       v;
    int unsigned sh;
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    w  = '0;
    sh = (b > 4'd4) ? 4 : int'(b);
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = ~a;
      3'b011: r = ~(a & b);
      3'b100: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[3:0];
        c = w[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'b101: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[3:0];
        c = ~w[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'b110: r = a << sh;
      default: r = a >> sh;
    endcase
    return {c, v, (r == 4'd0), r[3], r};
  endfunction

  always_comb begin
    {alu_c_in, alu_v_in, alu_z_in, alu_n_in, alu_res_in} = alu_ref(alu_a_out, alu_b_out, alu_op_out);
  end

  typedef struct {
    logic [3:0]       acc;
    logic [3:0]       flags;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  logic [3:0]       m_acc;
  logic [3:0]       m_flags;
  logic [CNT_W-1:0] m_cnt;
  int unsigned      n_checks = 0;
  int unsigned      n_pass = 0;
  int unsigned      cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc   = '0;
    m_flags = 4'b0010;
    m_cnt   = '0;
    sb.delete();
  endtask

  // Issues one command and follows it through EXEC into DONE; leaves DONE only if out_ready=1.
  task automatic send(input logic [1:0] cmd, input logic [2:0] op, input logic [3:0] b);
    int unsigned waited;
    exp_t        e;
    logic [7:0]  r;
    waited   = 0;
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_op    = op;
    in_b     = b;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    check("exec_alu_a", alu_a_out, m_acc);
    check("exec_alu_b", alu_b_out, b);
    check("exec_alu_op", alu_op_out, op);
    check("exec_out_valid", out_valid, 0);
    check("exec_in_ready", in_ready, 0);
    case (cmd)
      2'b00: begin
        r       = alu_ref(m_acc, b, op);
        m_acc   = r[3:0];
        m_flags = r[7:4];
      end
      2'b01: begin
        m_acc   = b;
        m_flags = {2'b00, (b == 4'd0), b[3]};
      end
      2'b11: begin
        m_acc   = '0;
        m_flags = 4'b0010;
      end
      default: ;
    endcase
    m_cnt = m_cnt + 1'b1;
    e.acc   = m_acc;
    e.flags = m_flags;
    e.cnt   = m_cnt;
    sb.push_back(e);
    tick();
    check("done_out_valid", out_valid, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("done_acc", acc_out, e.acc);
      check("done_flags", flags_out, e.flags);
      check("done_count", op_count_out, e.cnt);
    end
    if (out_ready) begin
      tick();
      check("back_idle_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned start_cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_cmd    = '0;
    in_op     = '0;
    in_b      = '0;
    out_ready = 1'b1;
    model_reset();

    // Reset
    tick();
    check("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready_release", in_ready, 1);
    check("rst_acc", acc_out, 4'b0000);
    check("rst_flags", flags_out, 4'b0010);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", op_count_out, 0);
    check("rst_alu_a", alu_a_out, 0);
    check("rst_alu_b", alu_b_out, 0);
    check("rst_alu_op", alu_op_out, 0);

    // LOAD then ADD overflowing into the sign bit
    send(2'b01, 3'b000, 4'b0111);
    check("load_acc", acc_out, 4'b0111);
    check("load_flags", flags_out, 4'b0000);
    send(2'b00, 3'b100, 4'b0001);
    check("add_acc", acc_out, 4'b1000);
    check("add_flags", flags_out, 4'b0101);
    check("add_count", op_count_out, 2);

    // Subtract to zero, then a saturating shift
    send(2'b01, 3'b000, 4'b0011);
    send(2'b00, 3'b101, 4'b0011);
    check("sub_acc", acc_out, 4'b0000);
    check("sub_flags", flags_out, 4'b1010);
    send(2'b01, 3'b000, 4'b0001);
    send(2'b00, 3'b110, 4'b0111);
    check("lsl_acc", acc_out, 4'b0000);
    check("lsl_flags", flags_out, 4'b0010);

    // Backpressure after CLEAR with in_valid toggling
    send(2'b01, 3'b000, 4'b1001);
    out_ready = 1'b0;
    send(2'b11, 3'b000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_cmd   = 2'b00;
      in_op    = 3'b100;
      in_b     = 4'hf;
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_acc", acc_out, 4'b0000);
      check("bp_flags", flags_out, 4'b0010);
      check("bp_count", op_count_out, m_cnt);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    tick();
    tick();
    check("bp_no_extra_count", op_count_out, m_cnt);
    check("bp_count_value", op_count_out, 8);

    // Mixed logic operations through the scoreboard
    send(2'b01, 3'b000, 4'b1100);
    send(2'b00, 3'b000, 4'b1010);
    send(2'b00, 3'b001, 4'b0101);
    send(2'b00, 3'b010, 4'b0000);
    send(2'b00, 3'b011, 4'b1111);
    send(2'b01, 3'b000, 4'b1000);
    send(2'b00, 3'b111, 4'b0010);
    check("lsr_acc", acc_out, 4'b0010);
    for (int i = 0; i < 6; i++) begin
      send(2'($urandom_range(3)), 3'($urandom_range(7)), 4'($urandom_range(15)));
    end

    // Reset during EXEC discards the command
    send(2'b01, 3'b000, 4'b0101);
    in_valid = 1'b1;
    in_cmd   = 2'b00;
    in_op    = 3'b100;
    in_b     = 4'b0001;
    tick();
    in_valid = 1'b0;
    check("midrst_alu_a", alu_a_out, 4'b0101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midrst_acc", acc_out, 4'b0000);
    check("midrst_flags", flags_out, 4'b0010);
    check("midrst_count", op_count_out, 0);
    for (int i = 0; i < 4; i++) begin
      check("midrst_out_valid", out_valid, 0);
      tick();
    end

    // 256 back-to-back NOPs wrap the counter
    start_cyc = cyc;
    for (int i = 0; i < 256; i++) begin
      send(2'b10, 3'($urandom_range(7)), 4'($urandom_range(15)));
    end
    check("wrap_cycles", cyc - start_cyc, 768);
    check("wrap_count", op_count_out, 0);
    check("wrap_acc", acc_out, 4'b0000);
    check("wrap_flags", flags_out, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
